u_butterfly_dec: RTL and testbench

- Bitstream-to-binary decoder for the four bipolar unary output streams of the unary butterfly (real0, img0, real1, img1).
- Counts ones over a fixed window of 2^BITWIDTH cycles and converts each count to a signed bipolar binary value.
- Presents all four results together with a valid/ready handshake.
- Sits downstream of the butterfly, on the result-readback side of the FFT datapath.

---
 rtl/u_butterfly_pkg.sv | 16 +
 rtl/u_stream_cnt.sv | 23 ++
 rtl/u_butterfly_dec.sv | 102 ++++++++++
 tb/tb_u_butterfly_dec.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/u_butterfly_pkg.sv
// Shared types and helpers for the unary butterfly result decoder.
// Holds the FSM states, the window length and the bipolar count-to-value conversion.
package u_butterfly_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  function automatic int windowLen(input int bitWidth);
    return 1 << bitWidth;
  endfunction

  // A bipolar stream with c ones in an N-cycle window encodes the value 2*c - N.
  function automatic int bipolarConv(input int onesCnt, input int bitWidth);
    return 2 * onesCnt - windowLen(bitWidth);
  endfunction

endpackage

// File: rtl/u_stream_cnt.sv
// Ones counter for a single unary stream.
// The counter is BITWIDTH+1 bits wide so that a full window of N ones still fits.
module u_stream_cnt #(
  parameter int BITWIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClr,
  input  logic              iEn,
  input  logic              iBit,
  output logic [BITWIDTH:0] oCnt
);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      oCnt <= '0;
    else if (iClr)
      oCnt <= '0;
    else if (iEn)
      oCnt <= oCnt + {{BITWIDTH{1'b0}}, iBit};
  end

endmodule

// File: rtl/u_butterfly_dec.sv
// Decodes the four bipolar output streams of the unary butterfly into signed binary values.
// It counts ones over a 2^BITWIDTH cycle window and hands the four results out through valid/ready.
module u_butterfly_dec
  import u_butterfly_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iStart,
  input  logic                       iReal0,
  input  logic                       iImg0,
  input  logic                       iReal1,
  input  logic                       iImg1,
  input  logic                       iReady,
  output logic                       oBusy,
  output logic                       oValid,
  output logic signed [BITWIDTH+1:0] oReal0,
  output logic signed [BITWIDTH+1:0] oImg0,
  output logic signed [BITWIDTH+1:0] oReal1,
  output logic signed [BITWIDTH+1:0] oImg1
);

  localparam int N  = windowLen(BITWIDTH);
  localparam int OW = BITWIDTH + 2;
  localparam logic [BITWIDTH-1:0] LAST_IDX = BITWIDTH'(N - 1);

  stateT state, nextState;
  logic [BITWIDTH-1:0] winCnt;
  logic [BITWIDTH:0]   cnt      [4];
  logic [BITWIDTH:0]   finalCnt [4];
  logic signed [OW-1:0] res     [4];
  logic [3:0] bits;
  logic startWin, runEn, lastSample;

  assign bits       = {iImg1, iReal1, iImg0, iReal0};
  assign startWin   = (state == IDLE) && iStart;
  assign runEn      = (state == RUN);
  assign lastSample = runEn && (winCnt == LAST_IDX);
  assign oBusy      = (state != IDLE);
  assign oValid     = (state == DONE);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = RUN;
      RUN:     if (winCnt == LAST_IDX) nextState = DONE;
      DONE:    if (iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      winCnt <= '0;
    else if (startWin)
      winCnt <= '0;
    else if (runEn)
      winCnt <= winCnt + 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : gCnt
    u_stream_cnt #(.BITWIDTH(BITWIDTH)) uStreamCnt (
      .iClk (iClk),
      .iRst (iRst),
      .iClr (startWin),
      .iEn  (runEn),
      .iBit (bits[g]),
      .oCnt (cnt[g])
    );
  end

  // The registered count lags one sample, so the last window bit is folded in here.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      finalCnt[k] = cnt[k] + {{BITWIDTH{1'b0}}, bits[k]};
      res[k]      = OW'(bipolarConv(int'(finalCnt[k]), BITWIDTH));
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oReal0 <= '0;
      oImg0  <= '0;
      oReal1 <= '0;
      oImg1  <= '0;
    end else if (lastSample) begin
      oReal0 <= res[0];
      oImg0  <= res[1];
      oReal1 <= res[2];
      oImg1  <= res[3];
    end
  end

endmodule

// File: tb/tb_u_butterfly_dec.sv
// Self-checking bench for u_butterfly_dec at BITWIDTH=4 (16-cycle window).
// Stream patterns come from a vector table; expected results go through a scoreboard queue.
module tb_u_butterfly_dec;

  localparam int BW = 4;
  localparam int N  = 16;

  logic iClk = 1'b0;
  logic iRst, iStart, iReal0, iImg0, iReal1, iImg1, iReady;
  logic oBusy, oValid;
  logic signed [BW+1:0] oReal0, oImg0, oReal1, oImg1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] r0, i0, r1, i1;
    int eR0, eI0, eR1, eI1;
  } vecT;

  typedef struct {
    int r0, i0, r1, i1;
  } expT;

  vecT vecs [5];
  expT sb [$];

  always #5 iClk = ~iClk;

  u_butterfly_dec #(.BITWIDTH(BW)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iReal0 (iReal0),
    .iImg0  (iImg0),
    .iReal1 (iReal1),
    .iImg1  (iImg1),
    .iReady (iReady),
    .oBusy  (oBusy),
    .oValid (oValid),
    .oReal0 (oReal0),
    .oImg0  (oImg0),
    .oReal1 (oReal1),
    .oImg1  (oImg1)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called on a negative edge with the DUT idle; returns on the negedge after edge t+N.
  task automatic applyStimulus(input vecT v, input bit midStart);
    expT e;
    e = '{v.eR0, v.eI0, v.eR1, v.eI1};
    sb.push_back(e);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int k = 0; k < N; k++) begin
      iReal0 = v.r0[k];
      iImg0  = v.i0[k];
      iReal1 = v.r1[k];
      iImg1  = v.i1[k];
      iStart = midStart && (k == 5);
      if (k == 8) checkOutput("busyInRun", int'(oBusy), 1);
      if (k == N - 1) checkOutput("validEarly", int'(oValid), 0);
      @(negedge iClk);
    end
    iStart = 1'b0;
    checkOutput("validLatency", int'(oValid), 1);
  endtask

  task automatic collectResult(input string tag);
    expT e;
    int waitCyc = 0;
    while (!oValid && waitCyc < 8) begin
      @(negedge iClk);
      waitCyc++;
    end
    if (!oValid || sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=valid%0d expected=valid1", tag, oValid);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_real0"}, int'(oReal0), e.r0);
    checkOutput({tag, "_img0"},  int'(oImg0),  e.i0);
    checkOutput({tag, "_real1"}, int'(oReal1), e.r1);
    checkOutput({tag, "_img1"},  int'(oImg1),  e.i1);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, -16, -16, -16, -16};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,  16,  16,  16,  16};
    vecs[2] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,   0,   0,   0,   0};
    vecs[3] = '{16'h0FFF, 16'h000F, 16'hFFFF, 16'h01FF,   8,  -8,  16,   2};
    vecs[4] = '{16'h0001, 16'h7FFF, 16'h00FF, 16'h8000, -14,  14,   0, -14};

    iRst = 1'b1; iStart = 1'b0; iReady = 1'b1;
    iReal0 = 1'b0; iImg0 = 1'b0; iReal1 = 1'b0; iImg1 = 1'b0;
    repeat (2) @(negedge iClk);
    checkOutput("rstValid", int'(oValid), 0);
    checkOutput("rstBusy",  int'(oBusy),  0);
    checkOutput("rstReal0", int'(oReal0), 0);
    checkOutput("rstImg1",  int'(oImg1),  0);
    iRst = 1'b0;
    @(negedge iClk);

    // Back-to-back windows with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], 1'b0);
      collectResult($sformatf("vec%0d", i));
      @(negedge iClk);
      checkOutput("validDrop", int'(oValid), 0);
      checkOutput("idleBusy",  int'(oBusy),  0);
      checkOutput("dataHeld",  int'(oReal0), vecs[i].eR0);
    end

    // Backpressure holds the result.
    iReady = 1'b0;
    applyStimulus(vecs[3], 1'b0);
    collectResult("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge iClk);
      checkOutput("bpValid", int'(oValid), 1);
      checkOutput("bpReal0", int'(oReal0), 8);
      checkOutput("bpImg1",  int'(oImg1),  2);
    end
    iReady = 1'b1;
    @(negedge iClk);
    checkOutput("bpRelValid", int'(oValid), 0);
    checkOutput("bpRelBusy",  int'(oBusy),  0);

    // iStart in RUN and in DONE (with iReady) must not restart.
    applyStimulus(vecs[4], 1'b1);
    collectResult("midStart");
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    checkOutput("doneStartValid", int'(oValid), 0);
    checkOutput("doneStartBusy",  int'(oBusy),  0);
    @(negedge iClk);
    checkOutput("stayIdle", int'(oBusy), 0);

    // Reset in the middle of a window.
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iReal0 = 1'b1; iImg0 = 1'b1; iReal1 = 1'b1; iImg1 = 1'b1;
    repeat (8) @(negedge iClk);
    iRst = 1'b1;
    #1;
    checkOutput("midRstBusy",  int'(oBusy),  0);
    checkOutput("midRstValid", int'(oValid), 0);
    checkOutput("midRstReal0", int'(oReal0), 0);
    checkOutput("midRstImg0",  int'(oImg0),  0);
    checkOutput("midRstImg1",  int'(oImg1),  0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    applyStimulus(vecs[3], 1'b0);
    collectResult("postRst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
